// File: rtl/vbsc_chain_if.sv
// Scan-side port bundle of the virtual boundary-scan chain: serial data,
// instruction and the DR-state flags coming from the TAP controller.
interface vbsc_chain_if #(
   parameter int IR_W = 2
);
   logic            tdi;
   logic            tdo;
   logic [IR_W-1:0] ir_in;
   logic            cdr;
   logic            sdr;
   logic            udr;

   modport master (output tdi, ir_in, cdr, sdr, udr, input tdo);
   modport slave  (input tdi, ir_in, cdr, sdr, udr, output tdo);
endinterface

// File: rtl/vbsc_chain.sv
// Virtual boundary-scan chain: NCELL IN/OE/OUT cells with a bypass register,
// an update register and the EXTEST pin mux in front of the IO buffers.
module vbsc_chain #(
   parameter int NCELL  = 4,
   parameter int IR_W   = 2,
   parameter bit RST_OE = 1'b0
) (
   input  logic             tck,
   input  logic             rst,
   vbsc_chain_if.slave      tap,
   input  logic [NCELL-1:0] pin_in,
   input  logic [NCELL-1:0] core_oe,
   input  logic [NCELL-1:0] core_out,
   output logic [NCELL-1:0] pin_oe,
   output logic [NCELL-1:0] pin_out,
   output logic [NCELL-1:0] core_in
);

   localparam int SR_W = 3 * NCELL;

   typedef enum logic [1:0] {
      INSTR_BYPASS = 2'd0,
      INSTR_SAMPLE = 2'd1,
      INSTR_EXTEST = 2'd2
   } instr_e;

   instr_e           instr;
   logic [IR_W+1:0]  ir_ext;
   logic             sr_sel;
   logic [SR_W-1:0]  sr;
   logic [SR_W-1:0]  cap_vec;
   logic             by;
   logic [NCELL-1:0] ur_oe;
   logic [NCELL-1:0] ur_out;

   // Widen before comparing so narrow IR_W cannot alias codes onto each other.
   always_comb begin
      ir_ext = {2'b00, tap.ir_in};
      instr  = INSTR_BYPASS;
      if (ir_ext == (IR_W+2)'(1))
         instr = INSTR_SAMPLE;
      else if (ir_ext == (IR_W+2)'(2))
         instr = INSTR_EXTEST;
   end

   assign sr_sel = (instr != INSTR_BYPASS);

   // Capture reflects what is actually on the pins, i.e. after the EXTEST mux.
   always_comb begin
      cap_vec = '0;
      for (int i = 0; i < NCELL; i++) begin
         cap_vec[3*i]   = pin_in[i];
         cap_vec[3*i+1] = pin_oe[i];
         cap_vec[3*i+2] = pin_out[i];
      end
   end

   // NOTE: all state here is updated with non-blocking assignments so every
   // branch reads the pre-edge values of sr/ur, matching register semantics.
   always_ff @(posedge tck) begin
      if (rst) begin
         sr     <= '0;
         by     <= 1'b0;
         ur_out <= '0;
         ur_oe  <= {NCELL{RST_OE}};
      end else if (tap.cdr) begin
         if (sr_sel)
            sr <= cap_vec;
         else
            by <= 1'b0;
      end else if (tap.sdr) begin
         if (sr_sel)
            sr <= {tap.tdi, sr[SR_W-1:1]};
         else
            by <= tap.tdi;
      end else if (tap.udr && sr_sel) begin
         for (int i = 0; i < NCELL; i++) begin
            ur_oe[i]  <= sr[3*i+1];
            ur_out[i] <= sr[3*i+2];
         end
      end
   end

   assign tap.tdo = tap.sdr ? (sr_sel ? sr[0] : by) : 1'b0;

   assign pin_oe  = (instr == INSTR_EXTEST) ? ur_oe  : core_oe;
   assign pin_out = (instr == INSTR_EXTEST) ? ur_out : core_out;
   assign core_in = pin_in;

endmodule

// File: tb/tb_vbsc_chain.sv
// Self-checking bench for vbsc_chain (NCELL=4): directed scenarios plus a
// randomized run against a queue-based behavioural model of the chain.
module tb_vbsc_chain;

   localparam int NCELL  = 4;
   localparam int IR_W   = 2;
   localparam int SR_W   = 3 * NCELL;
   localparam bit RST_OE = 1'b0;

   logic             tck = 1'b0;
   logic             rst;
   logic [NCELL-1:0] pin_in, core_oe, core_out;
   logic [NCELL-1:0] pin_oe, pin_out, core_in;

   int checks = 0;
   int errors = 0;

   // Model: m_sr[0] is the next bit to leave on tdo (cell 0 IN after capture).
   bit               m_sr[$];
   bit               m_by;
   logic [NCELL-1:0] m_ur_oe, m_ur_out;

   vbsc_chain_if #(.IR_W(IR_W)) tap ();

   vbsc_chain #(.NCELL(NCELL), .IR_W(IR_W), .RST_OE(RST_OE)) dut (
      .tck      (tck),
      .rst      (rst),
      .tap      (tap.slave),
      .pin_in   (pin_in),
      .core_oe  (core_oe),
      .core_out (core_out),
      .pin_oe   (pin_oe),
      .pin_out  (pin_out),
      .core_in  (core_in)
   );

   always #5 tck = ~tck;

   function automatic bit sel_sr();
      return (tap.ir_in == 2'd1) || (tap.ir_in == 2'd2);
   endfunction

   function automatic logic [NCELL-1:0] exp_oe();
      return (tap.ir_in == 2'd2) ? m_ur_oe : core_oe;
   endfunction

   function automatic logic [NCELL-1:0] exp_out();
      return (tap.ir_in == 2'd2) ? m_ur_out : core_out;
   endfunction

   function automatic logic exp_tdo();
      if (!tap.sdr) return 1'b0;
      return sel_sr() ? m_sr[0] : m_by;
   endfunction

   // Advance the model by the current inputs, then move past the next edge.
   task automatic tick();
      logic [NCELL-1:0] eo, ev;
      eo = exp_oe();
      ev = exp_out();
      if (rst) begin
         m_sr = {};
         repeat (SR_W) m_sr.push_back(1'b0);
         m_by     = 1'b0;
         m_ur_oe  = {NCELL{RST_OE}};
         m_ur_out = '0;
      end else if (tap.cdr) begin
         if (sel_sr()) begin
            m_sr = {};
            for (int i = 0; i < NCELL; i++) begin
               m_sr.push_back(pin_in[i]);
               m_sr.push_back(eo[i]);
               m_sr.push_back(ev[i]);
            end
         end else begin
            m_by = 1'b0;
         end
      end else if (tap.sdr) begin
         if (sel_sr()) begin
            void'(m_sr.pop_front());
            m_sr.push_back(tap.tdi);
         end else begin
            m_by = tap.tdi;
         end
      end else if (tap.udr && sel_sr()) begin
         for (int i = 0; i < NCELL; i++) begin
            m_ur_oe[i]  = m_sr[3*i+1];
            m_ur_out[i] = m_sr[3*i+2];
         end
      end
      @(posedge tck);
      #1;
   endtask

   task automatic flags_idle();
      rst     = 1'b0;
      tap.cdr = 1'b0;
      tap.sdr = 1'b0;
      tap.udr = 1'b0;
      tap.tdi = 1'b0;
   endtask

   // Shift the EXTEST pattern (OE=1, OUT=cell LSB), update, and check the pins.
   task automatic extest_scan(input string tag);
      bit pat[SR_W];
      for (int k = 0; k < SR_W; k++)
         pat[k] = (k % 3 == 0) ? 1'($urandom) : (k % 3 == 1) ? 1'b1 : 1'((k / 3) & 1);
      tap.ir_in = 2'd2;
      tap.sdr   = 1'b1;
      for (int k = 0; k < SR_W; k++) begin
         tap.tdi = pat[k];
         #1;
         checks++;
         if (tap.tdo !== exp_tdo()) begin
            errors++;
            $display("FAIL %s shift tdo[%0d]: got %b want %b", tag, k, tap.tdo, exp_tdo());
         end
         tick();
      end
      tap.sdr = 1'b0;
      tap.udr = 1'b1;
      #1;
      checks++;
      if (pin_oe !== exp_oe() || pin_out !== exp_out()) begin
         errors++;
         $display("FAIL %s pins before update edge: got oe=%b out=%b want oe=%b out=%b",
                  tag, pin_oe, pin_out, exp_oe(), exp_out());
      end
      tick();
      tap.udr = 1'b0;
      #1;
      checks++;
      if (pin_oe !== 4'b1111 || pin_out !== 4'b1010) begin
         errors++;
         $display("FAIL %s pins after update: got oe=%b out=%b want oe=1111 out=1010",
                  tag, pin_oe, pin_out);
      end
      core_oe  = 4'($urandom);
      core_out = 4'($urandom);
      #1;
      checks++;
      if (pin_oe !== 4'b1111 || pin_out !== 4'b1010) begin
         errors++;
         $display("FAIL %s pins vs core change: got oe=%b out=%b want oe=1111 out=1010",
                  tag, pin_oe, pin_out);
      end
   endtask

   task automatic test_reset();
      tap.ir_in = 2'd2;
      pin_in    = 4'($urandom);
      core_oe   = 4'($urandom);
      core_out  = 4'($urandom);
      rst       = 1'b1;
      tap.cdr   = 1'b1;
      tap.sdr   = 1'b1;
      tap.udr   = 1'b1;
      tap.tdi   = 1'b1;
      tick();
      tick();
      flags_idle();
      #1;
      checks++;
      if (pin_oe !== 4'b0000 || pin_out !== 4'b0000) begin
         errors++;
         $display("FAIL reset extest pins: got oe=%b out=%b want oe=0000 out=0000", pin_oe, pin_out);
      end
      checks++;
      if (tap.tdo !== 1'b0) begin
         errors++;
         $display("FAIL reset tdo: got %b want 0", tap.tdo);
      end
      tap.ir_in = 2'd0;
      #1;
      checks++;
      if (pin_oe !== core_oe || pin_out !== core_out) begin
         errors++;
         $display("FAIL reset bypass pins: got oe=%b out=%b want oe=%b out=%b",
                  pin_oe, pin_out, core_oe, core_out);
      end
      checks++;
      if (core_in !== pin_in) begin
         errors++;
         $display("FAIL core_in passthrough: got %b want %b", core_in, pin_in);
      end
   endtask

   task automatic test_sample_capture();
      logic [SR_W-1:0] exp_seq;
      exp_seq   = 12'b011_110_001_100;
      tap.ir_in = 2'd1;
      pin_in    = 4'b1010;
      core_oe   = 4'b0011;
      core_out  = 4'b0101;
      tap.cdr   = 1'b1;
      #1;
      tick();
      tap.cdr = 1'b0;
      tap.sdr = 1'b1;
      for (int k = 0; k < SR_W; k++) begin
         tap.tdi = 1'($urandom);
         #1;
         checks++;
         if (tap.tdo !== exp_seq[SR_W-1-k] || tap.tdo !== exp_tdo()) begin
            errors++;
            $display("FAIL sample tdo[%0d]: got %b want %b", k, tap.tdo, exp_seq[SR_W-1-k]);
         end
         tick();
      end
      tap.sdr = 1'b0;
   endtask

   task automatic test_extest_update();
      extest_scan("extest");
   endtask

   task automatic test_bypass();
      bit tdi_seq[3] = '{1'b1, 1'b0, 1'b1};
      bit tdo_seq[3] = '{1'b0, 1'b1, 1'b0};
      tap.ir_in = 2'd0;
      tap.cdr   = 1'b1;
      tick();
      tap.cdr = 1'b0;
      tap.sdr = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tap.tdi = tdi_seq[k];
         #1;
         checks++;
         if (tap.tdo !== tdo_seq[k]) begin
            errors++;
            $display("FAIL bypass tdo[%0d]: got %b want %b", k, tap.tdo, tdo_seq[k]);
         end
         tick();
      end
      tap.sdr = 1'b0;
      tap.udr = 1'b1;
      tick();
      tap.udr   = 1'b0;
      tap.ir_in = 2'd2;
      #1;
      checks++;
      if (pin_oe !== 4'b1111 || pin_out !== 4'b1010) begin
         errors++;
         $display("FAIL bypass udr kept ur: got oe=%b out=%b want oe=1111 out=1010", pin_oe, pin_out);
      end
   endtask

   task automatic test_reset_mid_scan();
      tap.ir_in = 2'd2;
      tap.sdr   = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tap.tdi = 1'($urandom);
         tick();
      end
      rst = 1'b1;
      tick();
      rst     = 1'b0;
      tap.sdr = 1'b0;
      #1;
      checks++;
      if (pin_oe !== {NCELL{RST_OE}} || pin_out !== 4'b0000) begin
         errors++;
         $display("FAIL mid-scan reset pins: got oe=%b out=%b want oe=%b out=0000",
                  pin_oe, pin_out, {NCELL{RST_OE}});
      end
      tap.sdr = 1'b1;
      #1;
      checks++;
      if (tap.tdo !== 1'b0) begin
         errors++;
         $display("FAIL mid-scan reset sr[0]: got %b want 0", tap.tdo);
      end
      tap.sdr = 1'b0;
      extest_scan("rescan");
   endtask

   task automatic test_cdr_sdr_overlap();
      logic cell0_in;
      tap.ir_in = 2'd1;
      pin_in    = 4'($urandom);
      cell0_in  = pin_in[0];
      tap.cdr   = 1'b1;
      tap.sdr   = 1'b1;
      tap.tdi   = 1'b1;
      tick();
      tap.cdr = 1'b0;
      pin_in  = ~pin_in;
      #1;
      checks++;
      if (tap.tdo !== cell0_in) begin
         errors++;
         $display("FAIL overlap first tdo: got %b want %b", tap.tdo, cell0_in);
      end
      tick();
      #1;
      checks++;
      if (tap.tdo !== exp_tdo()) begin
         errors++;
         $display("FAIL overlap second tdo: got %b want %b", tap.tdo, exp_tdo());
      end
      tap.sdr = 1'b0;
   endtask

   task automatic test_overshift();
      bit hist[20];
      tap.ir_in = 2'd1;
      tap.sdr   = 1'b1;
      for (int k = 0; k < 20; k++) begin
         hist[k] = 1'($urandom);
         tap.tdi = hist[k];
         tick();
      end
      for (int k = 0; k < SR_W; k++) begin
         tap.tdi = 1'b0;
         #1;
         checks++;
         if (tap.tdo !== hist[8+k]) begin
            errors++;
            $display("FAIL overshift tdo[%0d]: got %b want %b", k, tap.tdo, hist[8+k]);
         end
         tick();
      end
      tap.sdr = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         tap.ir_in = 2'($urandom_range(0, 3));
         rst       = ($urandom_range(0, 99) < 3);
         tap.cdr   = ($urandom_range(0, 99) < 25);
         tap.sdr   = ($urandom_range(0, 99) < 50);
         tap.udr   = ($urandom_range(0, 99) < 25);
         tap.tdi   = 1'($urandom);
         pin_in    = 4'($urandom);
         core_oe   = 4'($urandom);
         core_out  = 4'($urandom);
         #1;
         checks++;
         if (tap.tdo !== exp_tdo() || pin_oe !== exp_oe() || pin_out !== exp_out() ||
             core_in !== pin_in) begin
            errors++;
            $display("FAIL random[%0d]: got tdo=%b oe=%b out=%b cin=%b want tdo=%b oe=%b out=%b cin=%b",
                     n, tap.tdo, pin_oe, pin_out, core_in, exp_tdo(), exp_oe(), exp_out(), pin_in);
         end
         tick();
      end
      flags_idle();
   endtask

   initial begin
      m_sr = {};
      repeat (SR_W) m_sr.push_back(1'b0);
      m_by      = 1'b0;
      m_ur_oe   = {NCELL{RST_OE}};
      m_ur_out  = '0;
      rst       = 1'b1;
      tap.ir_in = '0;
      tap.cdr   = 1'b0;
      tap.sdr   = 1'b0;
      tap.udr   = 1'b0;
      tap.tdi   = 1'b0;
      pin_in    = '0;
      core_oe   = '0;
      core_out  = '0;
      #1;
      test_reset();
      test_sample_capture();
      test_extest_update();
      test_bypass();
      test_reset_mid_scan();
      test_cdr_sdr_overlap();
      test_overshift();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
